// File: rtl/infoflow_thread_sched.sv
// Two-thread scheduler for the 5-step high/low program sharing one low register.
// Optional bounded-wait fairness is compiled in with `define FAIR_SCHED_EN.
module infoflow_thread_sched #(
    parameter int unsigned MAX_WAIT = 3,
    parameter logic        INIT_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       high_choice_a,
    input  logic       high_choice_b,
    input  logic       sched_choice,
    output logic       low,
    output logic       high_a,
    output logic       high_b,
    output logic [2:0] pc_a,
    output logic [2:0] pc_b,
    output logic       halt_a,
    output logic       halt_b,
    output logic       grant,
    output logic       stepped,
    output logic       all_halt
);

    // Program steps; encodings 0, 6 and 7 are unreachable and execute as no-ops.
    typedef enum logic [2:0] {
        PC_LOAD   = 3'd1,
        PC_CLR    = 3'd2,
        PC_BRANCH = 3'd3,
        PC_SET    = 3'd4,
        PC_HALT   = 3'd5
    } pc_t;

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_max_wait_range
        $error("MAX_WAIT must lie in 1..15");
    end

    logic       run_a;
    logic       run_b;
    logic       any_run;
    logic       sel;
    logic [2:0] cur_pc;
    logic       cur_high;
    logic       cur_choice;
    logic [2:0] nxt_pc;
    logic       nxt_high;
    logic       nxt_halt;
    logic       nxt_low;

    assign run_a    = !halt_a;
    assign run_b    = !halt_b;
    assign any_run  = run_a | run_b;
    assign all_halt = halt_a & halt_b;

`ifdef FAIR_SCHED_EN
    logic [3:0] wait_a;
    logic [3:0] wait_b;

    always_comb begin
        sel = 1'b0;
        if (run_a && run_b) begin
            if (wait_a == 4'(MAX_WAIT))
                sel = 1'b0;
            else if (wait_b == 4'(MAX_WAIT))
                sel = 1'b1;
            else
                sel = sched_choice;
        end else if (run_b) begin
            sel = 1'b1;
        end
    end

    // A counter only runs while its thread is passed over; any grant or halt clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_a <= 4'd0;
            wait_b <= 4'd0;
        end else begin
            wait_a <= (run_a && sel)  ? wait_a + 4'd1 : 4'd0;
            wait_b <= (run_b && !sel) ? wait_b + 4'd1 : 4'd0;
        end
    end
`else
    always_comb begin
        sel = 1'b0;
        if (run_a && run_b)
            sel = sched_choice;
        else if (run_b)
            sel = 1'b1;
    end
`endif

    assign cur_pc     = sel ? pc_b : pc_a;
    assign cur_high   = sel ? high_b : high_a;
    assign cur_choice = sel ? high_choice_b : high_choice_a;

    // Next-state of the selected thread; the other thread is simply not written.
    always_comb begin
        nxt_pc   = cur_pc;
        nxt_high = cur_high;
        nxt_halt = 1'b0;
        nxt_low  = low;
        case (cur_pc)
            PC_LOAD: begin
                nxt_high = cur_choice;
                nxt_pc   = PC_CLR;
            end
            PC_CLR: begin
                nxt_low = 1'b0;
                nxt_pc  = PC_BRANCH;
            end
            PC_BRANCH: nxt_pc = cur_high ? PC_SET : PC_HALT;
            PC_SET: begin
                nxt_low = 1'b1;
                nxt_pc  = PC_HALT;
            end
            PC_HALT: nxt_halt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_a    <= PC_LOAD;
            pc_b    <= PC_LOAD;
            high_a  <= 1'b0;
            high_b  <= 1'b0;
            halt_a  <= 1'b0;
            halt_b  <= 1'b0;
            low     <= INIT_LOW;
            grant   <= 1'b0;
            stepped <= 1'b0;
        end else if (any_run) begin
            low     <= nxt_low;
            grant   <= sel;
            stepped <= 1'b1;
            if (sel) begin
                pc_b   <= nxt_pc;
                high_b <= nxt_high;
                halt_b <= nxt_halt;
            end else begin
                pc_a   <= nxt_pc;
                high_a <= nxt_high;
                halt_a <= nxt_halt;
            end
        end else begin
            stepped <= 1'b0;
        end
    end

endmodule

// File: tb/tb_infoflow_thread_sched.sv
// Table-driven bench for infoflow_thread_sched plus hand-written reset and frozen-state sequences.
module tb_infoflow_thread_sched;

    logic       clk;
    logic       rst;
    logic       high_choice_a;
    logic       high_choice_b;
    logic       sched_choice;
    logic       low;
    logic       high_a;
    logic       high_b;
    logic [2:0] pc_a;
    logic [2:0] pc_b;
    logic       halt_a;
    logic       halt_b;
    logic       grant;
    logic       stepped;
    logic       all_halt;

    int n_cmp;
    int n_bad;

    // Observation vector: {low, high_a, high_b, pc_a, pc_b, halt_a, halt_b, grant, stepped, all_halt}
    typedef struct {
        logic        rst;
        logic        hca;
        logic        hcb;
        logic        sc;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[$];

    infoflow_thread_sched #(.MAX_WAIT(3), .INIT_LOW(1'b0)) dut (
        .clk          (clk),
        .rst          (rst),
        .high_choice_a(high_choice_a),
        .high_choice_b(high_choice_b),
        .sched_choice (sched_choice),
        .low          (low),
        .high_a       (high_a),
        .high_b       (high_b),
        .pc_a         (pc_a),
        .pc_b         (pc_b),
        .halt_a       (halt_a),
        .halt_b       (halt_b),
        .grant        (grant),
        .stepped      (stepped),
        .all_halt     (all_halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic hca, input logic hcb, input logic sc,
                                input logic l, input logic ha, input logic hb,
                                input logic [2:0] pa, input logic [2:0] pb,
                                input logic hla, input logic hlb, input logic g, input logic st);
        vec_t v;
        v.rst = r;
        v.hca = hca;
        v.hcb = hcb;
        v.sc  = sc;
        v.exp = {l, ha, hb, pa, pb, hla, hlb, g, st, hla & hlb};
        return v;
    endfunction

    function automatic logic [13:0] observe();
        return {low, high_a, high_b, pc_a, pc_b, halt_a, halt_b, grant, stepped, all_halt};
    endfunction

    task automatic drive(input logic r, input logic hca, input logic hcb, input logic sc);
        rst           = r;
        high_choice_a = hca;
        high_choice_b = hcb;
        sched_choice  = sc;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (low,ha,hb,pca,pcb,hla,hlb,grant,stepped,all_halt)",
                     name, got, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        high_choice_a = 1'b0;
        high_choice_b = 1'b0;
        sched_choice = 1'b0;

        // Reset held two cycles
        vecs.push_back(mk(1, 0, 0, 0,  0, 0, 0, 3'd1, 3'd1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,  0, 0, 0, 3'd1, 3'd1, 0, 0, 0, 0));
`ifndef FAIR_SCHED_EN
        // Serial run: A (high=1) five steps, then B (high=0) four steps despite sched_choice=0
        vecs.push_back(mk(0, 1, 0, 0,  0, 1, 0, 3'd2, 3'd1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0,  0, 1, 0, 3'd3, 3'd1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0,  0, 1, 0, 3'd4, 3'd1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0,  1, 1, 0, 3'd5, 3'd1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0,  1, 1, 0, 3'd5, 3'd1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0,  1, 1, 0, 3'd5, 3'd2, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0,  0, 1, 0, 3'd5, 3'd3, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0,  0, 1, 0, 3'd5, 3'd5, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0,  0, 1, 0, 3'd5, 3'd5, 1, 1, 1, 1));
        vecs.push_back(mk(0, 1, 1, 1,  0, 1, 0, 3'd5, 3'd5, 1, 1, 1, 0));
`else
        // Fair run, MAX_WAIT=3: A,A,A, forced B, A,A, then B finishes alone
        vecs.push_back(mk(0, 1, 0, 0,  0, 1, 0, 3'd2, 3'd1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0,  0, 1, 0, 3'd3, 3'd1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0,  0, 1, 0, 3'd4, 3'd1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0,  0, 1, 0, 3'd4, 3'd2, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0,  1, 1, 0, 3'd5, 3'd2, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0,  1, 1, 0, 3'd5, 3'd2, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0,  0, 1, 0, 3'd5, 3'd3, 1, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0,  0, 1, 0, 3'd5, 3'd5, 1, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0,  0, 1, 0, 3'd5, 3'd5, 1, 1, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0,  0, 1, 0, 3'd5, 3'd5, 1, 1, 1, 0));
`endif
        // Interleaved run with alternating picks: B's high=1 reaches low
        vecs.push_back(mk(1, 0, 0, 0,  0, 0, 0, 3'd1, 3'd1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1,  0, 0, 1, 3'd1, 3'd2, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0,  0, 0, 1, 3'd2, 3'd2, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 1,  0, 0, 1, 3'd2, 3'd3, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 1, 3'd3, 3'd3, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1,  0, 0, 1, 3'd3, 3'd4, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 1, 3'd5, 3'd4, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1,  1, 0, 1, 3'd5, 3'd5, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0,  1, 0, 1, 3'd5, 3'd5, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0,  1, 0, 1, 3'd5, 3'd5, 1, 1, 1, 1));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].hca, vecs[i].hcb, vecs[i].sc);
            check($sformatf("vec%0d", i), observe(), vecs[i].exp);
        end

        // Both halted: random inputs must not disturb any state
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check($sformatf("frozen%0d", k), observe(),
                  {1'b1, 1'b0, 1'b1, 3'd5, 3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
        end

        // Reset while A sits at PC4: the pending low<=1 must not land
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("mid_pc4", observe(), {1'b0, 1'b1, 1'b0, 3'd4, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check("mid_reset", observe(), {1'b0, 1'b0, 1'b0, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        check("post_reset_step", observe(), {1'b0, 1'b0, 1'b1, 3'd1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
